// File: rtl/booth_pp_issue.sv
// Multiplier stage-M1: operand register, valid/ready pipeline control into M2,
// and radix-4 Booth partial-product generation transposed into product columns.
module booth_pp_issue #(
  parameter int unsigned COLS = 66,
  parameter int unsigned NPP  = 17
) (
  input  logic                 mul_clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_src1,
  input  logic [31:0]          in_src2,
  input  logic                 in_signed,
  input  logic                 in_high,
  input  logic                 cancel,
  output logic [COLS*NPP-1:0]  pp_cols,
  output logic [NPP-1:0]       neg_bits,
  output logic                 M1_ready_go,
  output logic                 M1_out_ready,
  output logic                 m1_valid,
  output logic                 m2_valid,
  output logic                 m2_high,
  input  logic                 m2_ready
);

  logic [31:0] src1_q, src2_q;
  logic        signed_q, high_q;
  logic        m1_valid_q, m1_valid_d;
  logic        m2_valid_q, m2_valid_d;
  logic        m2_high_q, m2_high_d;
  logic        accept, advance, consume, load_ops;

  assign M1_ready_go  = m1_valid_q;
  assign M1_out_ready = !m2_valid_q || m2_ready;
  assign advance      = M1_ready_go && M1_out_ready;
  assign in_ready     = !m1_valid_q || advance;
  assign accept       = in_valid && in_ready;
  assign consume      = m2_valid_q && m2_ready;
  assign load_ops     = accept && !cancel;

  assign m1_valid = m1_valid_q;
  assign m2_valid = m2_valid_q;
  assign m2_high  = m2_high_q;

  always_comb begin
    m1_valid_d = m1_valid_q;
    m2_valid_d = m2_valid_q;
    m2_high_d  = m2_high_q;
    if (cancel) begin
      m1_valid_d = 1'b0;
      m2_valid_d = 1'b0;
    end else begin
      if (accept) begin
        m1_valid_d = 1'b1;
      end else if (advance) begin
        m1_valid_d = 1'b0;
      end
      if (advance) begin
        m2_valid_d = 1'b1;
        m2_high_d  = high_q;
      end else if (consume) begin
        m2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      src1_q     <= '0;
      src2_q     <= '0;
      signed_q   <= 1'b0;
      high_q     <= 1'b0;
      m1_valid_q <= 1'b0;
      m2_valid_q <= 1'b0;
      m2_high_q  <= 1'b0;
    end else begin
      if (load_ops) begin
        src1_q   <= in_src1;
        src2_q   <= in_src2;
        signed_q <= in_signed;
        high_q   <= in_high;
      end
      m1_valid_q <= m1_valid_d;
      m2_valid_q <= m2_valid_d;
      m2_high_q  <= m2_high_d;
    end
  end

  logic [32:0]     x33, y33;
  logic [COLS-1:0] x1, x2;
  logic [34:0]     yext;
  logic [COLS-1:0] pp [NPP];
  logic [2:0]      grp;
  logic [COLS-1:0] mult;
  logic            neg, zero;

  assign x33  = {signed_q & src1_q[31], src1_q};
  assign y33  = {signed_q & src2_q[31], src2_q};
  assign x1   = {{(COLS-33){x33[32]}}, x33};
  assign x2   = {x1[COLS-2:0], 1'b0};
  // yext[k] holds y[k-1]: bit 0 is the implicit y[-1], bit 34 repeats y[32].
  assign yext = {y33[32], y33, 1'b0};

  always_comb begin
    neg_bits = '0;
    grp      = '0;
    mult     = '0;
    neg      = 1'b0;
    zero     = 1'b1;
    for (int unsigned i = 0; i < NPP; i++) begin
      grp = yext[2*i +: 3];
      unique case (grp)
        3'b001, 3'b010: begin mult = x1; neg = 1'b0; zero = 1'b0; end
        3'b011:         begin mult = x2; neg = 1'b0; zero = 1'b0; end
        3'b100:         begin mult = x2; neg = 1'b1; zero = 1'b0; end
        3'b101, 3'b110: begin mult = x1; neg = 1'b1; zero = 1'b0; end
        default:        begin mult = '0; neg = 1'b0; zero = 1'b1; end
      endcase
      pp[i]       = zero ? '0 : ((neg ? ~mult : mult) << (2*i));
      neg_bits[i] = neg;
    end
  end

  always_comb begin
    pp_cols = '0;
    for (int unsigned j = 0; j < COLS; j++) begin
      for (int unsigned i = 0; i < NPP; i++) begin
        pp_cols[j*NPP + i] = pp[i][j];
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_issue.sv
// Randomized and directed check of booth_pp_issue against a transaction-level
// pipeline model and an arithmetic Booth-digit model of the partial products.
module tb_booth_pp_issue;
  localparam int COLS = 66;
  localparam int NPP  = 17;

  logic                mul_clk = 1'b0;
  logic                reset, in_valid, in_ready, in_signed, in_high, cancel;
  logic [31:0]         in_src1, in_src2;
  logic [COLS*NPP-1:0] pp_cols;
  logic [NPP-1:0]      neg_bits;
  logic                M1_ready_go, M1_out_ready, m1_valid, m2_valid, m2_high, m2_ready;

  int total = 0;
  int bad   = 0;

  booth_pp_issue #(.COLS(COLS), .NPP(NPP)) dut (
    .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_signed(in_signed), .in_high(in_high),
    .cancel(cancel), .pp_cols(pp_cols), .neg_bits(neg_bits),
    .M1_ready_go(M1_ready_go), .M1_out_ready(M1_out_ready), .m1_valid(m1_valid),
    .m2_valid(m2_valid), .m2_high(m2_high), .m2_ready(m2_ready)
  );

  always #5 mul_clk = ~mul_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Model state: what M1 and M2 should hold.
  logic        mdl_m1, mdl_m2, mdl_m2h, m2h_known, ops_known;
  logic [31:0] mdl_a, mdl_b;
  logic        mdl_s, mdl_h;
  int          accepts = 0;

  function automatic logic [65:0] ext(input logic [31:0] v, input logic s);
    return s ? {{34{v[31]}}, v} : {34'b0, v};
  endfunction

  function automatic int ybit(input logic [31:0] b, input logic s, input int k);
    logic [65:0] y;
    y = ext(b, s);
    if (k < 0) return 0;
    return int'(y[k]);
  endfunction

  function automatic int digit(input logic [31:0] b, input logic s, input int i);
    return ybit(b, s, 2*i-1) + ybit(b, s, 2*i) - 2*ybit(b, s, 2*i+1);
  endfunction

  function automatic logic [65:0] exp_pp(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input int i);
    logic [65:0] mag;
    int d;
    d   = digit(b, s, i);
    mag = ext(a, s) * 66'(d < 0 ? -d : d);
    if (d == 0) return '0;
    if (d > 0) return mag << (2*i);
    return (66'd0 - mag - 66'd1) << (2*i);
  endfunction

  task automatic cycle();
    logic        e_out_rdy, e_in_rdy, adv, acc, cons;
    logic [65:0] obs_pp, sum, prod;
    logic [NPP-1:0] e_neg;
    @(negedge mul_clk);
    e_out_rdy = !mdl_m2 || m2_ready;
    e_in_rdy  = !mdl_m1 || e_out_rdy;
    chk("m1_valid", 128'(m1_valid), 128'(mdl_m1));
    chk("m2_valid", 128'(m2_valid), 128'(mdl_m2));
    chk("M1_ready_go", 128'(M1_ready_go), 128'(mdl_m1));
    chk("M1_out_ready", 128'(M1_out_ready), 128'(e_out_rdy));
    chk("in_ready", 128'(in_ready), 128'(e_in_rdy));
    if (m2h_known) chk("m2_high", 128'(m2_high), 128'(mdl_m2h));
    if (ops_known) begin
      sum = '0;
      for (int i = 0; i < NPP; i++) begin
        for (int j = 0; j < COLS; j++) obs_pp[j] = pp_cols[j*NPP + i];
        chk($sformatf("pp%0d", i), 128'(obs_pp), 128'(exp_pp(mdl_a, mdl_b, mdl_s, i)));
        e_neg[i] = digit(mdl_b, mdl_s, i) < 0;
        sum = sum + obs_pp + (66'(neg_bits[i]) << (2*i));
      end
      prod = ext(mdl_a, mdl_s) * ext(mdl_b, mdl_s);
      chk("neg_bits", 128'(neg_bits), 128'(e_neg));
      chk("pp_sum", 128'(sum), 128'(prod));
    end
    if (reset) begin
      mdl_m1 = 0; mdl_m2 = 0; mdl_m2h = 0; m2h_known = 1;
      mdl_a = '0; mdl_b = '0; mdl_s = 0; mdl_h = 0; ops_known = 1;
    end else if (cancel) begin
      mdl_m1 = 0; mdl_m2 = 0; m2h_known = 0; ops_known = 0;
    end else begin
      adv  = mdl_m1 && e_out_rdy;
      acc  = in_valid && e_in_rdy;
      cons = mdl_m2 && m2_ready;
      if (adv) begin
        mdl_m2 = 1; mdl_m2h = mdl_h; m2h_known = 1;
      end else if (cons) mdl_m2 = 0;
      if (acc) begin
        mdl_m1 = 1; mdl_a = in_src1; mdl_b = in_src2; mdl_s = in_signed; mdl_h = in_high;
        ops_known = 1; accepts++;
      end else if (adv) mdl_m1 = 0;
    end
    @(posedge mul_clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] b, input logic s, input logic h);
    in_valid = 1; in_src1 = a; in_src2 = b; in_signed = s; in_high = h;
    cycle();
    in_valid = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'(int'($urandom_range(0, 7)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int a0;
    reset = 1; in_valid = 0; in_src1 = '0; in_src2 = '0; in_signed = 0; in_high = 0;
    cancel = 0; m2_ready = 1;
    mdl_m1 = 0; mdl_m2 = 0; mdl_m2h = 0; m2h_known = 0; ops_known = 0;
    mdl_a = '0; mdl_b = '0; mdl_s = 0; mdl_h = 0;
    @(posedge mul_clk); #1;
    cycle(); cycle();
    reset = 0;
    cycle();

    req(32'd3, 32'd5, 0, 1); cycle(); cycle();
    req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0); cycle();
    req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1); cycle();
    req(32'h8000_0000, 32'h8000_0000, 1, 0); cycle(); cycle();

    a0 = accepts;
    req(32'd11, 32'd13, 1, 1); req(32'hDEAD_BEEF, 32'd7, 0, 0);
    req(32'h1234_5678, 32'h8765_4321, 1, 1); req(32'd2, 32'hFFFF_FFFE, 1, 1);
    chk("b2b_accepts", 128'(accepts - a0), 128'(4));
    cycle(); cycle(); cycle();

    m2_ready = 0;
    req(32'd100, 32'd200, 0, 1);
    req(32'hCAFE_0001, 32'h8000_0001, 1, 0);
    in_valid = 1; in_src1 = 32'd9; in_src2 = 32'd9; in_high = 1;
    cycle(); cycle(); cycle();
    m2_ready = 1;
    cycle(); in_valid = 0; cycle(); cycle(); cycle();

    m2_ready = 0;
    req(32'd5, 32'd6, 0, 0); req(32'd7, 32'd8, 1, 1);
    in_valid = 1; cancel = 1; cycle(); cancel = 0; in_valid = 0;
    m2_ready = 1; cycle(); cycle();

    req(32'd21, 32'd22, 1, 1); req(32'd23, 32'd24, 0, 0);
    in_valid = 1; reset = 1; cycle(); reset = 0; in_valid = 0; cycle(); cycle();

    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_src1   = pick();
      in_src2   = pick();
      in_signed = 1'($urandom);
      in_high   = 1'($urandom);
      m2_ready  = ($urandom_range(0, 3) != 0);
      cancel    = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      cycle();
    end
    reset = 0; cancel = 0; in_valid = 0; m2_ready = 1;
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_pp_issue.md
Name: booth_pp_issue

Overview:
- Multiplier stage-M1 front end and pipeline controller.
- Accepts 32x32 multiply requests over a valid/ready handshake and registers the operands in the M1 operand register.
- Produces 17 radix-4 Booth partial products, transposed into 66 columns of 17 bits, for the wallace column slices.
- Drives the M1 handshake to the slices (M1_ready_go, M1_out_ready) and carries the hi/lo sideband into M2 in lockstep with the slices' internal pipeline register.

Parameters:
- COLS, 66, number of product columns (2 x 33-bit extended operands).
- NPP, 17, number of Booth partial products (fixed by 33-bit multiplier).

Ports:
- mul_clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_src1  in  32  multiplicand
- in_src2  in  32  multiplier
- in_signed  in  1  1 = signed x signed, 0 = unsigned x unsigned
- in_high  in  1  1 = result wants product[63:32], 0 = product[31:0]
- cancel  in  1  flush: kill M1 and M2 contents
- pp_cols  out  COLS*NPP  column j bits at [17j+16:17j]; bit i = partial product i, bit j
- neg_bits  out  NPP  Booth negate bit i, weight 2^(2i)
- M1_ready_go  out  1  M1 work complete
- M1_out_ready  out  1  M2 can accept
- m1_valid  out  1  M1 register holds a live request
- m2_valid  out  1  M2 (slice register) holds a live request
- m2_high  out  1  sideband aligned with M2
- m2_ready  in  1  downstream final adder/writeback accepts M2

Behaviour:
Reset and flush:
- reset: m1_valid=0, m2_valid=0, m2_high=0, operand registers=0 (pp_cols all 0, neg_bits=0).
- reset mid-operation discards everything; no partial result emerges.
- cancel (when not reset): m1_valid<=0, m2_valid<=0 next edge; any same-cycle accept is dropped.

Handshake:
- M1_ready_go = m1_valid (single-cycle stage).
- M1_out_ready = !m2_valid | m2_ready.
- in_ready = !m1_valid | (M1_ready_go & M1_out_ready). Combinational; must not depend on in_valid.
- Accept edge: X and Y registers load, and m1_valid <= 1.
- If M1 advances (M1_ready_go & M1_out_ready) with no accept: m1_valid <= 0.
- M1 advance also loads m2_valid <= 1 and m2_high <= M1 sideband.
- If M2 is consumed (m2_valid & m2_ready) with no M1 advance: m2_valid <= 0.
- Simultaneous consume and advance: m2_valid stays 1 with the new sideband.
- Back-to-back throughput: 1 request per cycle when m2_ready is held 1.
- Latency: accept at edge t; pp_cols valid during cycle t+1; slices capture at edge t+1 if M1_out_ready; m2_valid high in cycle t+2.
- Operand registers hold while stalled; pp_cols must stay stable while m1_valid and !M1_out_ready.

Arithmetic (combinational from the registers):
- X = 66-bit extension of {in_signed & src1[31], src1}.
- Y33 = {in_signed & src2[31], src2}; y[-1]=0, y[33]=y[32].
- Group i (0..16) uses {y[2i+1], y[2i], y[2i-1]}:
  - 000, 111 -> 0
  - 001, 010 -> +X
  - 011 -> +2X
  - 100 -> -2X
  - 101, 110 -> -X
- PP_i = (positive: M; negative: ~M) << 2i, truncated to 66 bits, zeros shifted in. M is X or X<<1.
- Zero group: PP_i = 0, neg=0. Negative groups: neg_bits[i]=1.
- Invariant: sum(PP_i) + sum(neg_bits[i]<<2i) mod 2^66 == X*Y33 sign-correct 64-bit product, extended.

Test Plan:
- src1=3, src2=5, unsigned, m2_ready=1 -> in_ready=1; cycle t+1: neg_bits=0, column sums+neg model = 15; m2_valid high cycle t+2, m2_high=in_high.
- src1=0xFFFFFFFF, src2=0xFFFFFFFF, signed -> model product = 1; unsigned -> 0xFFFFFFFE00000001.
- src1=0x80000000, src2=0x80000000, signed -> model 0x4000000000000000; neg_bits[15] pattern matches group decode.
- Back-to-back: 4 requests with m2_ready=1 -> one accept per cycle, m2_valid continuous, m2_high follows the in_high sequence 1,0,1,1.
- Backpressure: m2_valid=1, m2_ready=0, new request in M1 -> M1_out_ready=0, in_ready=0, pp_cols stable; release m2_ready -> both advance same edge.
- cancel with M1 and M2 full; separately reset mid-stream -> next cycle m1_valid=m2_valid=0, in_ready=1, no stale result.
